// File: rtl/cypher_arbiter.sv
// Two-requester round-robin arbiter that owns one shared cypher_detector per session:
// it clears and arms the detector, streams the granted requester's digits into it, and reports hit/sum.
module cypher_arbiter #(
  parameter int unsigned MAX_DIGITS   = 32,
  parameter int unsigned DRAIN_CYCLES = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req0,
  input  logic        req1,
  input  logic [15:0] cypher0,
  input  logic [15:0] cypher1,
  input  logic [3:0]  num0,
  input  logic [3:0]  num1,
  input  logic        valid0,
  input  logic        valid1,
  output logic        ready0,
  output logic        ready1,
  output logic [1:0]  gnt,
  output logic [1:0]  done,
  output logic        hit,
  output logic [7:0]  result_sum,
  output logic        det_reset,
  output logic        det_read,
  output logic [15:0] det_cypher,
  output logic [3:0]  det_num,
  input  logic        det_right,
  input  logic [7:0]  det_sum,
  output logic        busy
);

  localparam logic [7:0] MAX_CNT    = 8'(MAX_DIGITS);
  localparam logic [3:0] DRAIN_LAST = 4'(DRAIN_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_ARM,
    S_STREAM,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t      r_state;
  state_t      w_next_state;

  logic        r_gnt_idx;
  logic        r_rr_prefer;
  logic [15:0] r_cypher;
  logic [3:0]  r_det_num;
  logic [7:0]  r_digit_cnt;
  logic [3:0]  r_drain_cnt;
  logic        r_hit;
  logic [7:0]  r_result_sum;
  logic        r_det_reset;

  logic        w_any_req;
  logic        w_pick;
  logic        w_req_g;
  logic        w_valid_g;
  logic [3:0]  w_num_g;
  logic        w_ready_g;
  logic        w_accept;
  logic        w_last_digit;
  logic        w_hit_next;
  logic [1:0]  w_gnt_onehot;

  // The requester other than the last one served wins a tie.
  assign w_any_req    = req0 | req1;
  assign w_pick       = (req0 && req1) ? r_rr_prefer : req1;

  assign w_req_g      = r_gnt_idx ? req1   : req0;
  assign w_valid_g    = r_gnt_idx ? valid1 : valid0;
  assign w_num_g      = r_gnt_idx ? num1   : num0;
  assign w_gnt_onehot = r_gnt_idx ? 2'b10  : 2'b01;

  assign w_ready_g    = (r_state == S_STREAM) && (r_digit_cnt < MAX_CNT);
  assign w_accept     = w_ready_g && w_valid_g;
  assign w_last_digit = w_accept && (r_digit_cnt == MAX_CNT - 8'd1);

  // State register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples pre-edge values regardless of process evaluation order.
      r_state <= w_next_state;
    end
  end

  // Next-state logic. det_right outranks abort, budget and timeout exits.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves
    // it unassigned and infers a latch.
    w_next_state = r_state;
    w_hit_next   = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (w_any_req) w_next_state = S_CLEAR;
      end
      S_CLEAR: begin
        if (!w_req_g && !det_right) w_next_state = S_DONE;
        else                        w_next_state = S_ARM;
      end
      S_ARM: begin
        if (!w_req_g && !det_right) w_next_state = S_DONE;
        else                        w_next_state = S_STREAM;
      end
      S_STREAM: begin
        if (det_right) begin
          w_next_state = S_DONE;
          w_hit_next   = 1'b1;
        end else if (!w_req_g) begin
          w_next_state = S_DONE;
        end else if (w_last_digit) begin
          w_next_state = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (det_right) begin
          w_next_state = S_DONE;
          w_hit_next   = 1'b1;
        end else if (!w_req_g || (r_drain_cnt == DRAIN_LAST)) begin
          w_next_state = S_DONE;
        end
      end
      S_DONE: begin
        w_next_state = S_IDLE;
      end
      default: begin
        w_next_state = S_IDLE;
      end
    endcase
  end

  // Output decode from the current state.
  always_comb begin
    gnt      = 2'b00;
    done     = 2'b00;
    ready0   = 1'b0;
    ready1   = 1'b0;
    det_read = 1'b0;
    busy     = (r_state != S_IDLE);
    if (r_state != S_IDLE) gnt  = w_gnt_onehot;
    if (r_state == S_DONE) done = w_gnt_onehot;
    ready0   = w_ready_g && !r_gnt_idx;
    ready1   = w_ready_g &&  r_gnt_idx;
    det_read = (r_state == S_ARM) || (r_state == S_STREAM) || (r_state == S_DRAIN);
  end

  // Session datapath: grant latch, digit path, counters and result capture.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_gnt_idx    <= 1'b0;
      r_rr_prefer  <= 1'b0;
      r_cypher     <= '0;
      r_det_num    <= '0;
      r_digit_cnt  <= '0;
      r_drain_cnt  <= '0;
      r_hit        <= 1'b0;
      r_result_sum <= '0;
      r_det_reset  <= 1'b1;
    end else begin
      r_det_reset <= (w_next_state == S_CLEAR);

      if (r_state == S_IDLE && w_any_req) begin
        r_gnt_idx <= w_pick;
        r_cypher  <= w_pick ? cypher1 : cypher0;
      end

      if (r_state == S_CLEAR) begin
        r_digit_cnt <= '0;
      end else if (w_accept && (r_digit_cnt != 8'hFF)) begin
        r_digit_cnt <= r_digit_cnt + 8'd1;
      end

      if (w_accept) r_det_num <= w_num_g;

      if (r_state != S_DRAIN) begin
        r_drain_cnt <= '0;
      end else if (r_drain_cnt != 4'hF) begin
        r_drain_cnt <= r_drain_cnt + 4'd1;
      end

      // Result is captured once, on the edge that enters DONE, then held.
      if (w_next_state == S_DONE && r_state != S_DONE) begin
        r_hit        <= w_hit_next;
        r_result_sum <= det_sum;
      end

      if (r_state == S_DONE) r_rr_prefer <= ~r_gnt_idx;
    end
  end

  assign hit        = r_hit;
  assign result_sum = r_result_sum;
  assign det_reset  = r_det_reset;
  assign det_cypher = r_cypher;
  assign det_num    = r_det_num;

endmodule
